// File: rtl/mac_window_accumulator.sv
// Windowed signed MAC accumulator: sums N_TERMS input terms per window and hands the
// window sum plus a sticky signed-overflow flag downstream over valid/ready.
module mac_window_accumulator #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned N_TERMS = 50,
  parameter int unsigned CNT_W   = $clog2(N_TERMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  term_cnt
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] data_ext;
  logic [ACC_W-1:0] sum;
  logic             ovf_step;
  logic             accept;
  logic             last_term;

  assign data_ext  = ACC_W'($signed(in_data));
  assign sum       = acc_q + data_ext;
  // Signed overflow: operands agree in sign but the wrapped result does not.
  assign ovf_step  = (acc_q[ACC_W-1] == data_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_term = (cnt_q == CNT_W'(N_TERMS - 1));

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (last_term) begin
        // Completion overrides a same-cycle consume so windows run back-to-back.
        out_sum_d   = sum;
        out_ovf_d   = ovf_acc_q | ovf_step;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_acc_d   = 1'b0;
      end else begin
        acc_d     = sum;
        cnt_d     = cnt_q + CNT_W'(1);
        ovf_acc_d = ovf_acc_q | ovf_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_mac_window_accumulator.sv
// Directed bench for mac_window_accumulator: a segment table on the 32-bit instance
// plus hand-written sequences, and a 16-bit instance for overflow windows.
module tb_mac_window_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [15:0] in_data;
  logic [31:0] out_sum;
  logic [5:0]  term_cnt;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, out_ovf16;
  logic [15:0] in_data16, out_sum16;
  logic [5:0]  term_cnt16;

  mac_window_accumulator #(.DATA_W(16), .ACC_W(32), .N_TERMS(50)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
    .term_cnt(term_cnt)
  );

  mac_window_accumulator #(.DATA_W(16), .ACC_W(16), .N_TERMS(50)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_data(in_data16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_sum(out_sum16), .out_ovf(out_ovf16), .term_cnt(term_cnt16)
  );

  int n_vec = 0;
  int n_bad = 0;

  // One segment: hold inputs for reps cycles, then expect the outputs listed.
  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    int          reps;
    logic        e_ov;
    logic [31:0] e_sum;
    logic        e_ovf;
    logic [5:0]  e_cnt;
    logic        e_ir;
  } seg_t;

  seg_t tab[$];

  task automatic add(input logic r, input logic iv, input int d, input logic ordy,
                     input int reps, input logic e_ov, input logic [31:0] e_sum,
                     input logic e_ovf, input int e_cnt, input logic e_ir);
    seg_t s;
    s.rst = r; s.iv = iv; s.d = 16'(d); s.ordy = ordy; s.reps = reps;
    s.e_ov = e_ov; s.e_sum = e_sum; s.e_ovf = e_ovf; s.e_cnt = 6'(e_cnt); s.e_ir = e_ir;
    tab.push_back(s);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b1;

    //  rst iv  data  ordy reps  ov  sum           ovf cnt ir
    add(1, 0,    0,   1,   2,    0,  32'd0,        0,  0,  1);  // reset state
    add(0, 1,    1,   1,   49,   0,  32'd0,        0,  49, 1);
    add(0, 1,    1,   1,   1,    1,  32'd50,       0,  0,  1);
    add(0, 0,    0,   1,   1,    0,  32'd50,       0,  0,  1);
    add(0, 1,   -3,   1,   50,   1,  32'hFFFFFF6A, 0,  0,  1);
    add(0, 0,    0,   1,   1,    0,  32'hFFFFFF6A, 0,  0,  1);
    add(0, 1,    2,   0,   50,   1,  32'd100,      0,  0,  0);  // backpressure
    add(0, 1,    2,   0,   10,   1,  32'd100,      0,  0,  0);
    add(0, 1,    2,   1,   1,    0,  32'd100,      0,  1,  1);  // consume + resume
    add(0, 1,    2,   1,   49,   1,  32'd100,      0,  0,  1);
    add(0, 0,    0,   1,   1,    0,  32'd100,      0,  0,  1);
    add(0, 1,    5,   1,   20,   0,  32'd100,      0,  20, 1);  // mid-window reset
    add(1, 1,    5,   1,   1,    0,  32'd0,        0,  0,  1);
    add(0, 1,    1,   1,   50,   1,  32'd50,       0,  0,  1);
    add(0, 0,    0,   1,   1,    0,  32'd50,       0,  0,  1);
    add(0, 1,    3,   0,   50,   1,  32'd150,      0,  0,  0);  // reset with pending
    add(1, 1,    3,   0,   1,    0,  32'd0,        0,  0,  1);
    add(0, 0,    0,   1,   3,    0,  32'd0,        0,  0,  1);

    for (int i = 0; i < tab.size(); i++) begin
      rst = tab[i].rst; in_valid = tab[i].iv; in_data = tab[i].d; out_ready = tab[i].ordy;
      repeat (tab[i].reps) step();
      chk($sformatf("seg%0d out_valid", i), 32'(out_valid), 32'(tab[i].e_ov));
      chk($sformatf("seg%0d out_sum", i), out_sum, tab[i].e_sum);
      chk($sformatf("seg%0d out_ovf", i), 32'(out_ovf), 32'(tab[i].e_ovf));
      chk($sformatf("seg%0d term_cnt", i), 32'(term_cnt), 32'(tab[i].e_cnt));
      chk($sformatf("seg%0d in_ready", i), 32'(in_ready), 32'(tab[i].e_ir));
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Basic window: term_cnt walks 0..49, single-cycle out_valid pulse.
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("basic term_cnt %0d", i), 32'(term_cnt), 32'(i));
      chk($sformatf("basic out_valid %0d", i), 32'(out_valid), 32'd0);
      in_valid = 1'b1; in_data = 16'd1;
      step();
    end
    in_valid = 1'b0;
    chk("basic done valid", 32'(out_valid), 32'd1);
    chk("basic done sum", out_sum, 32'd50);
    chk("basic done cnt", 32'(term_cnt), 32'd0);
    step();
    chk("basic pulse width", 32'(out_valid), 32'd0);

    // Alternating +7/-7 nets zero without overflow.
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_data = (i % 2 == 0) ? 16'd7 : 16'hFFF9;
      step();
    end
    in_valid = 1'b0;
    chk("alt valid", 32'(out_valid), 32'd1);
    chk("alt sum", out_sum, 32'd0);
    chk("alt ovf", 32'(out_ovf), 32'd0);
    step();

    // Back-to-back windows: in_ready never drops, pulses after terms 50 and 100.
    for (int c = 1; c <= 100; c++) begin
      chk($sformatf("b2b in_ready %0d", c), 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = (c <= 50) ? 16'd1 : 16'd4;
      step();
      chk($sformatf("b2b out_valid %0d", c), 32'(out_valid), 32'(c == 50 || c == 100));
      if (c == 50)  chk("b2b sum A", out_sum, 32'd50);
      if (c == 100) chk("b2b sum B", out_sum, 32'd200);
    end
    in_valid = 1'b0;
    step();
    chk("b2b idle valid", 32'(out_valid), 32'd0);

    // 16-bit accumulator overflow windows.
    for (int i = 0; i < 50; i++) begin
      in_valid16 = 1'b1; in_data16 = 16'd1000;
      step();
    end
    chk("ovf16 valid", 32'(out_valid16), 32'd1);
    chk("ovf16 sum", 32'(out_sum16), 32'h0000C350);
    chk("ovf16 flag", 32'(out_ovf16), 32'd1);
    for (int i = 0; i < 50; i++) begin
      in_valid16 = 1'b1; in_data16 = 16'd1;
      step();
    end
    chk("ovf16 clean sum", 32'(out_sum16), 32'd50);
    chk("ovf16 clean flag", 32'(out_ovf16), 32'd0);
    // 40 x +1000 wraps, 10 x -1000 returns to 30000; flag stays sticky.
    for (int i = 0; i < 50; i++) begin
      in_valid16 = 1'b1; in_data16 = (i < 40) ? 16'd1000 : 16'hFC18;
      step();
    end
    in_valid16 = 1'b0;
    chk("ovf16 reentry sum", 32'(out_sum16), 32'd30000);
    chk("ovf16 reentry flag", 32'(out_ovf16), 32'd1);
    chk("ovf16 term_cnt", 32'(term_cnt16), 32'd0);
    step();
    chk("ovf16 idle valid", 32'(out_valid16), 32'd0);
    chk("ovf16 in_ready", 32'(in_ready16), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
